// File: rtl/feature_map_fetch_pkg.sv
// Shared types and constants for the feature-map fetch read master.
// Imported by fetch_fifo and feature_map_fetch.
package feature_map_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        FINISH
    } fetch_state_t;

    localparam int WORD_W      = 16;
    localparam int ADDR_STRIDE = WORD_W / 8;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO buffering returned read words for the output stream.
// Same-cycle push and pop are supported; flush empties it at once.
module fetch_fifo
    import feature_map_fetch_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic [clog2(DEPTH):0]  count,
    output logic                   full,
    output logic                   empty
);

    localparam int PTR_W = clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == (PTR_W + 1)'(DEPTH));
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign dout    = empty ? '0 : mem[rd_ptr];

    // Storage array; left unreset since empty masks stale contents.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/feature_map_fetch.sv
// Avalon-MM pipelined read master streaming feature-map words to conv.
// Optional abort port enabled by macro FEATURE_MAP_FETCH_ABORT_EN.
module feature_map_fetch
    import feature_map_fetch_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [CNT_W-1:0]    word_count,
    output logic                busy,
    output logic                done,
    output logic                read_n,
    output logic                write_n,
    output logic                chipselect,
    input  logic                waitrequest,
    output logic [ADDR_W-1:0]   address,
    output logic [DATA_W/8-1:0] byteenable,
    input  logic                readdatavalid,
    input  logic [DATA_W-1:0]   readdata,
    output logic [DATA_W-1:0]   out_data,
    output logic                out_valid,
    input  logic                out_ready
`ifdef FEATURE_MAP_FETCH_ABORT_EN
    ,
    input  logic                abort
`endif
);

    localparam int OUT_W = clog2(FIFO_DEPTH) + 1;
    localparam logic [OUT_W:0] DEPTH_L = (OUT_W + 1)'(FIFO_DEPTH);

    fetch_state_t       state;
    fetch_state_t       state_n;
    logic [ADDR_W-1:0]  addr_q;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   issued;
    logic [CNT_W-1:0]   issued_nxt;
    logic [CNT_W-1:0]   popped;
    logic [CNT_W-1:0]   popped_nxt;
    logic [OUT_W-1:0]   outstanding;
    logic [OUT_W-1:0]   fifo_count;
    logic [OUT_W:0]     credit_used;
    logic               fifo_full;
    logic               fifo_empty;
    logic               read_req;
    logic               accept;
    logic               rdv_dec;
    logic               push;
    logic               pop;
    logic               stop;
    logic               stop_done;
    logic               flush;

    assign credit_used = {1'b0, fifo_count} + {1'b0, outstanding};
    assign read_req    = (state == ISSUE) && (credit_used < DEPTH_L)
                         && (issued < count_q) && !stop;
    assign accept      = read_req && !waitrequest;
    assign issued_nxt  = issued + 1'b1;
    assign rdv_dec     = readdatavalid && (outstanding != '0);
    assign push        = rdv_dec && !flush;
    assign pop         = out_valid && out_ready;
    assign popped_nxt  = popped + CNT_W'(pop);

    assign read_n      = !read_req;
    assign chipselect  = read_req;
    assign write_n     = 1'b1;
    assign byteenable  = '1;
    assign address     = addr_q;
    assign out_valid   = !fifo_empty;
    assign busy        = (state == ISSUE) || (state == DRAIN);
    assign done        = (state == FINISH);

`ifdef FEATURE_MAP_FETCH_ABORT_EN
    logic aborting_q;
    logic stall_q;
    logic abort_go;

    assign abort_go  = busy && (abort || aborting_q);
    assign stop      = abort_go && !stall_q;
    assign flush     = abort_go;
    assign stop_done = abort_go && !read_req && (outstanding == '0);

    // Abort latch; a stalled read is let through to its accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            aborting_q <= 1'b0;
            stall_q    <= 1'b0;
        end else begin
            aborting_q <= (state == FINISH) ? 1'b0
                        : (aborting_q || (abort && busy));
            stall_q    <= read_req && waitrequest;
        end
    end
`else
    assign stop      = 1'b0;
    assign flush     = 1'b0;
    assign stop_done = 1'b0;
`endif

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .din   (readdata),
        .dout  (out_data),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // Next state; a zero-length job idles one cycle in DRAIN so that
    // done lands two cycles after start.
    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (start) state_n = (word_count == '0) ? DRAIN : ISSUE;
            end
            ISSUE: begin
                if (stop_done) state_n = FINISH;
                else if (accept && (issued_nxt == count_q)) state_n = DRAIN;
            end
            DRAIN: begin
                if (stop_done) state_n = FINISH;
                else if ((outstanding == '0) && (popped_nxt == count_q))
                    state_n = FINISH;
            end
            FINISH:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Job registers, address walk and transaction counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q      <= '0;
            count_q     <= '0;
            issued      <= '0;
            popped      <= '0;
            outstanding <= '0;
        end else begin
            if (state == IDLE && start) begin
                addr_q  <= base_addr;
                count_q <= word_count;
                issued  <= '0;
                popped  <= '0;
            end else begin
                if (accept) begin
                    addr_q <= addr_q + ADDR_W'(ADDR_STRIDE);
                    issued <= issued_nxt;
                end
                if (pop) popped <= popped_nxt;
            end
            case ({accept, rdv_dec})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    // The credit rule must keep the FIFO from ever overflowing.
    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(push && fifo_full && !pop));

endmodule

// File: tb/tb_feature_map_fetch.sv
// Self-checking bench for feature_map_fetch with an Avalon slave model
// and a scoreboard on the output stream.
module tb_feature_map_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] base_addr;
    logic [15:0] word_count;
    logic        busy;
    logic        done;
    logic        read_n;
    logic        write_n;
    logic        chipselect;
    logic        waitrequest = 1'b0;
    logic [31:0] address;
    logic [1:0]  byteenable;
    logic        readdatavalid = 1'b0;
    logic [15:0] readdata = 16'h0;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;

    int tests = 0;
    int fails = 0;
    logic [15:0] sb[$];
    logic [15:0] pend[$];
    logic [31:0] addr_log[$];
    int acc_total = 0;
    int pops = 0;
    int dones = 0;
    int read_low = 0;
    int stall_at = -1;
    int stall_left = 0;
    logic [31:0] stall_addr = 32'h0;

    feature_map_fetch dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .base_addr     (base_addr),
        .word_count    (word_count),
        .busy          (busy),
        .done          (done),
        .read_n        (read_n),
        .write_n       (write_n),
        .chipselect    (chipselect),
        .waitrequest   (waitrequest),
        .address       (address),
        .byteenable    (byteenable),
        .readdatavalid (readdatavalid),
        .readdata      (readdata),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] word_of(input logic [31:0] a);
        return a[16:1] ^ 16'h5A3C;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Slave model: one-cycle read latency, optional stall on one read.
    always @(negedge clk) begin
        if (reset) begin
            pend.delete();
            readdatavalid = 1'b0;
            waitrequest   = 1'b0;
        end else begin
            waitrequest = 1'b0;
            if (!read_n && acc_total == stall_at && stall_left > 0) begin
                waitrequest = 1'b1;
                stall_left--;
                check("stall_addr", address, stall_addr);
                check("stall_cs", {31'b0, chipselect}, 32'd1);
            end
            if (pend.size() > 0) begin
                readdatavalid = 1'b1;
                readdata      = pend.pop_front();
            end else begin
                readdatavalid = 1'b0;
            end
            if (!read_n) read_low++;
            if (!read_n && !waitrequest) begin
                acc_total++;
                addr_log.push_back(address);
                sb.push_back(word_of(address));
                pend.push_back(word_of(address));
            end
        end
    end

    // Stream monitor against the scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            if (done) dones++;
            if (out_valid && out_ready) begin
                pops++;
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $error("FAIL sb_underflow observed=%h expected=none",
                           out_data);
                end else begin
                    check("stream_data", out_data, sb.pop_front());
                end
            end
        end
    end

    task automatic check_reset();
        check("rst_read_n", read_n, 1);
        check("rst_write_n", write_n, 1);
        check("rst_cs", chipselect, 0);
        check("rst_addr", address, 0);
        check("rst_be", byteenable, 3);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
    endtask

    task automatic start_job(input logic [31:0] b, input logic [15:0] n);
        @(posedge clk); #1;
        start      = 1'b1;
        base_addr  = b;
        word_count = n;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int cyc);
        cyc = 1;
        while (!done && cyc < limit) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (!done) begin
            tests++;
            fails++;
            $error("FAIL done_timeout observed=%0d expected<%0d", cyc, limit);
        end
    endtask

    task automatic check_log(input string tag, input logic [31:0] b,
                             input int n);
        logic [31:0] a;
        check({tag, "_count"}, addr_log.size(), n);
        a = b;
        for (int i = 0; i < n && i < addr_log.size(); i++) begin
            check(tag, addr_log[i], a);
            a = a + 32'd2;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc;
        int d0;
        int a0;
        int p0;
        int rl;
        int k;

        reset      = 1'b1;
        start      = 1'b0;
        base_addr  = 32'h0;
        word_count = 16'h0;
        out_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset();
        reset = 1'b0;

        addr_log.delete();
        d0 = dones;
        start_job(32'h1000, 16'd4);
        check("first_read_n", read_n, 0);
        check("first_busy", busy, 1);
        check("first_addr", address, 32'h1000);
        wait_done(100, cyc);
        check("basic_done_cycle", cyc, 7);
        check("basic_busy_at_done", busy, 0);
        @(posedge clk); #1;
        check("basic_done_pulse", done, 0);
        check("basic_done_count", dones - d0, 1);
        check_log("basic_addr", 32'h1000, 4);
        check("basic_sb_empty", sb.size(), 0);

        addr_log.delete();
        stall_at   = acc_total + 1;
        stall_left = 3;
        stall_addr = 32'h1002;
        start_job(32'h1000, 16'd4);
        wait_done(100, cyc);
        check("stall_done_cycle", cyc, 10);
        check("stall_applied", stall_left, 0);
        @(posedge clk); #1;
        check_log("stall_log", 32'h1000, 4);
        check("stall_sb_empty", sb.size(), 0);
        stall_at = -1;

        addr_log.delete();
        out_ready = 1'b0;
        a0 = acc_total;
        p0 = pops;
        start_job(32'h2000, 16'd40);
        repeat (50) @(posedge clk);
        #1;
        check("bp_issued", acc_total - a0, 16);
        check("bp_read_n", read_n, 1);
        check("bp_busy", busy, 1);
        check("bp_hold_valid", out_valid, 1);
        check("bp_hold_data", out_data, word_of(32'h2000));
        out_ready = 1'b1;
        wait_done(500, cyc);
        @(posedge clk); #1;
        check("bp_pops", pops - p0, 40);
        check("bp_sb_empty", sb.size(), 0);
        check_log("bp_addr", 32'h2000, 40);

        rl = read_low;
        d0 = dones;
        start_job(32'h5000, 16'd0);
        check("zero_c1_done", done, 0);
        check("zero_c1_busy", busy, 1);
        @(posedge clk); #1;
        check("zero_c2_done", done, 1);
        check("zero_c2_busy", busy, 0);
        @(posedge clk); #1;
        check("zero_pulse", done, 0);
        check("zero_no_reads", read_low - rl, 0);
        check("zero_done_count", dones - d0, 1);

        addr_log.delete();
        start_job(32'hFFFF_FFFE, 16'd2);
        wait_done(100, cyc);
        @(posedge clk); #1;
        check("wrap_a0", addr_log.size() > 0 ? addr_log[0] : 32'hDEAD,
              32'hFFFF_FFFE);
        check("wrap_a1", addr_log.size() > 1 ? addr_log[1] : 32'hDEAD,
              32'h0000_0000);
        check("wrap_sb_empty", sb.size(), 0);

        p0 = pops;
        start_job(32'h3000, 16'd20);
        k = 0;
        while (pops - p0 < 5 && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        check("mid_reached_5", (pops - p0 >= 5) ? 1 : 0, 1);
        reset = 1'b1;
        #1;
        check_reset();
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        check_reset();
        reset = 1'b0;
        addr_log.delete();
        p0 = pops;
        start_job(32'h4000, 16'd3);
        wait_done(100, cyc);
        @(posedge clk); #1;
        check_log("post_rst_addr", 32'h4000, 3);
        check("post_rst_pops", pops - p0, 3);
        check("post_rst_sb", sb.size(), 0);
        check("post_rst_busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
